// File: rtl/ro_meas_ctrl.sv
// Ring oscillator sequencer and frequency meter: gates the ring, lets it settle,
// then counts synchronized rising edges of its output over a clk-cycle window.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | ring gated off, waiting for start
// S_SETTLE  | ring enabled, edges ignored until the settle timer expires
// S_MEASURE | ring enabled, edge pulses counted until the window timer expires
// S_DONE    | one-cycle result strobe; rearm the window (cont) or go idle
module ro_meas_ctrl #(
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 8,
   parameter int WIN_BASE   = 256,
   parameter int SEL_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cont,
   input  logic [SEL_W-1:0] win_sel,
   input  logic             ro_in,
   output logic             ro_en,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int WIN_W = $clog2(WIN_BASE) + (1 << SEL_W);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t           state;
   logic [2:0]       ro_sync;
   logic             edge_pulse;
   logic [SEL_W-1:0] sel_q;
   logic [TMR_W-1:0] tmr;
   logic             tmr_tc;
   logic [CNT_W-1:0] edge_cnt;
   logic             ovf_acc;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;

   // Terminal value of the window down-counter: window length minus one.
   function automatic logic [TMR_W-1:0] win_last(input logic [SEL_W-1:0] sel);
      return (TMR_W'(WIN_BASE) << sel) - TMR_W'(1);
   endfunction

   assign edge_pulse = ro_sync[1] & ~ro_sync[2];
   assign tmr_tc     = (tmr == '0);

   always_comb begin
      cnt_next = edge_cnt;
      ovf_next = ovf_acc;
      if (edge_pulse) begin
         if (&edge_cnt) ovf_next = 1'b1;
         else           cnt_next = edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ro_sync  <= '0;
         sel_q    <= '0;
         tmr      <= '0;
         edge_cnt <= '0;
         ovf_acc  <= 1'b0;
         ro_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         valid    <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         ro_sync <= {ro_sync[1:0], ro_in};
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               ro_en <= 1'b0;
               busy  <= 1'b0;
               if (start && !abort) begin
                  sel_q    <= win_sel;
                  edge_cnt <= '0;
                  ovf_acc  <= 1'b0;
                  tmr      <= TMR_W'(SETTLE_CYC);
                  busy     <= 1'b1;
                  state    <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  ro_en <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  ro_en <= 1'b1;
                  if (tmr_tc) begin
                     tmr   <= win_last(sel_q);
                     state <= S_MEASURE;
                  end else begin
                     tmr <= tmr - TMR_W'(1);
                  end
               end
            end
            S_MEASURE: begin
               if (abort) begin
                  ro_en <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  edge_cnt <= cnt_next;
                  ovf_acc  <= ovf_next;
                  if (tmr_tc) begin
                     // Result includes the final window cycle's pulse.
                     count    <= cnt_next;
                     overflow <= ovf_next;
                     valid    <= 1'b1;
                     done     <= 1'b1;
                     ro_en    <= cont;
                     state    <= S_DONE;
                  end else begin
                     tmr <= tmr - TMR_W'(1);
                  end
               end
            end
            S_DONE: begin
               if (cont && !abort) begin
                  sel_q    <= win_sel;
                  tmr      <= win_last(win_sel);
                  edge_cnt <= '0;
                  ovf_acc  <= 1'b0;
                  ro_en    <= 1'b1;
                  state    <= S_MEASURE;
               end else begin
                  ro_en <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               ro_en <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
